// File: rtl/kyber_hpm_host_if.sv
// kyber_hpm_host_if
// Host-side streaming wrapper around the Kyber polynomial core. One command
// stages N coefficients from the s_* stream and loads them into the core in
// the core's interleaved order. It then starts the transform, waits for done,
// reads the result back into the same staging buffer and drains it in natural
// order on the m_* stream.
// Optional feature: define HOSTIF_DONE_TMO_EN to build a watchdog on done
// (TMO cycles in WAIT without done -> ERR, err=1 until reset).
//
// Handshake rule (cmd_*, s_*, m_*): a transfer happens on a rising edge where
// valid and ready are both high. The valid side holds its data stable until
// that edge. The ready side may raise or drop ready on any cycle.
//
// N must be a power of two (>= 4): the load and capture orders are bit
// permutations of the index counter.
module kyber_hpm_host_if #(
    parameter int DW  = 12,
    parameter int N   = 256,
    parameter int TMO = 4096
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_intt,
    input  logic          cmd_sel_b,
    input  logic          s_valid,
    output logic          s_ready,
    input  logic [DW-1:0] s_data,
    output logic          m_valid,
    input  logic          m_ready,
    output logic [DW-1:0] m_data,
    output logic          load_a_f,
    output logic          load_a_i,
    output logic          load_b_f,
    output logic          load_b_i,
    output logic          read_a,
    output logic          read_b,
    output logic          start_ab,
    output logic          start_fntt,
    output logic          start_intt,
    output logic          start_pwm2,
    output logic [DW-1:0] din,
    input  logic [DW-1:0] dout,
    input  logic          done,
    output logic          busy,
    output logic          err,
    output logic [3:0]    dbg_state
);
    localparam int AW = $clog2(N);
    localparam int CW = $clog2(N + 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(N);

    typedef enum logic [3:0] {
        S_IDLE, S_FILL, S_LOAD, S_GAP1, S_START, S_GAP2, S_WAIT,
        S_RGAP0, S_READ, S_RGAP, S_CAPT, S_DRAIN, S_ERR
    } state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic          cnt_inc;
    logic          op_intt, op_sel_b;
    logic          enter_load;
    logic [DW-1:0] buffer [N];
    logic [AW-1:0] idx, load_addr, capt_addr;

    // LOAD sends 4k+0, 4k+2, 4k+1, 4k+3: the two low index bits swapped.
    // CAPT writes m, m+N/2 alternately: the index rotated right by one.
    assign idx       = cnt[AW-1:0];
    assign load_addr = {idx[AW-1:2], idx[0], idx[1]};
    assign capt_addr = {idx[0], idx[AW-1:1]};

    assign cmd_ready  = (state == S_IDLE);
    assign busy       = (state != S_IDLE);
    assign s_ready    = (state == S_FILL);
    assign m_valid    = (state == S_DRAIN);
    assign m_data     = (state == S_DRAIN) ? buffer[idx] : '0;
    assign start_pwm2 = 1'b0;
    assign dbg_state  = state;
    assign enter_load = (state == S_FILL) && (state_nx == S_LOAD);

`ifdef HOSTIF_DONE_TMO_EN
    localparam int TW = (TMO > 1) ? $clog2(TMO) : 1;
    logic [TW-1:0] tmo_cnt;
    logic          tmo_hit;

    // Count cycles spent in WAIT; cleared whenever the block is elsewhere.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)              tmo_cnt <= '0;
        else if (state == S_WAIT) tmo_cnt <= tmo_cnt + 1'b1;
        else                     tmo_cnt <= '0;
    end

    assign tmo_hit = (tmo_cnt == TW'(TMO - 1));

    // err follows entry into ERR, which only reset leaves.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) err <= 1'b0;
        else        err <= (state_nx == S_ERR);
    end
`else
    // Constant 0 for any legal TMO: the watchdog is not built.
    assign err = (TMO < 0);
`endif

    // Next-state logic: fixed-length phases count on cnt, the stream phases
    // advance only on accepted beats.
    always_comb begin
        state_nx = state;
        cnt_inc  = 1'b0;
        case (state)
            S_IDLE:  if (cmd_valid) state_nx = S_FILL;
            S_FILL: begin
                cnt_inc = s_valid;
                if (s_valid && cnt == CNT_LAST) state_nx = S_LOAD;
            end
            S_LOAD: begin
                cnt_inc = 1'b1;
                if (cnt == CNT_FULL) state_nx = S_GAP1;
            end
            S_GAP1: begin
                cnt_inc = 1'b1;
                if (cnt == CNT_ONE) state_nx = S_START;
            end
            S_START: state_nx = S_GAP2;
            S_GAP2: begin
                cnt_inc = 1'b1;
                if (cnt == CNT_ONE) state_nx = S_WAIT;
            end
            S_WAIT: begin
                if (done) state_nx = S_RGAP0;
`ifdef HOSTIF_DONE_TMO_EN
                else if (tmo_hit) state_nx = S_ERR;
`endif
            end
            S_RGAP0: state_nx = S_READ;
            S_READ:  state_nx = S_RGAP;
            S_RGAP: begin
                cnt_inc = 1'b1;
                if (cnt == CNT_ONE) state_nx = S_CAPT;
            end
            S_CAPT: begin
                cnt_inc = 1'b1;
                if (cnt == CNT_LAST) state_nx = S_DRAIN;
            end
            S_DRAIN: begin
                cnt_inc = m_ready;
                if (m_ready && cnt == CNT_LAST) state_nx = S_IDLE;
            end
            S_ERR:   state_nx = S_ERR;
            default: state_nx = S_IDLE;
        endcase
    end

    // State, phase counter (cleared on every state change) and command latch.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            cnt      <= '0;
            op_intt  <= 1'b0;
            op_sel_b <= 1'b0;
        end else begin
            state <= state_nx;
            if (state_nx != state) cnt <= '0;
            else if (cnt_inc)      cnt <= cnt + 1'b1;
            if (state == S_IDLE && cmd_valid) begin
                op_intt  <= cmd_intt;
                op_sel_b <= cmd_sel_b;
            end
        end
    end

    // Core control pulses, registered so each is high for exactly the
    // LOAD-entry, START or READ cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            load_a_f   <= 1'b0;
            load_a_i   <= 1'b0;
            load_b_f   <= 1'b0;
            load_b_i   <= 1'b0;
            start_fntt <= 1'b0;
            start_intt <= 1'b0;
            start_ab   <= 1'b0;
            read_a     <= 1'b0;
            read_b     <= 1'b0;
        end else begin
            load_a_f   <= enter_load && !op_sel_b && !op_intt;
            load_a_i   <= enter_load && !op_sel_b &&  op_intt;
            load_b_f   <= enter_load &&  op_sel_b && !op_intt;
            load_b_i   <= enter_load &&  op_sel_b &&  op_intt;
            start_fntt <= (state_nx == S_START) && !op_intt;
            start_intt <= (state_nx == S_START) &&  op_intt;
            start_ab   <= (state_nx == S_START) &&  op_sel_b;
            read_a     <= (state_nx == S_READ)  && !op_sel_b;
            read_b     <= (state_nx == S_READ)  &&  op_sel_b;
        end
    end

    // din shows one permuted coefficient per cycle after the load pulse,
    // 0 at all other times.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                               din <= '0;
        else if (state == S_LOAD && cnt != CNT_FULL) din <= buffer[load_addr];
        else                                      din <= '0;
    end

    // Staging buffer: filled from s_data, later overwritten by captured dout.
    always_ff @(posedge clk) begin
        if (state == S_FILL && s_valid) buffer[idx]       <= s_data;
        else if (state == S_CAPT)       buffer[capt_addr] <= dout;
    end
endmodule

// File: doc/kyber_hpm_host_if.md
KYBER_HPM_HOST_IF -- requirements
Module: kyber_hpm_host_if

Interface
- REQ-001 SHALL have parameters: DW, 12, coefficient width; N, 256, coefficients per polynomial; TMO, 4096, done-watchdog limit in cycles.
- REQ-002 SHALL have ports:
  - clk  in  1  sole clock, rising edge.
  - reset  in  1  asynchronous, active-low.
  - cmd_valid  in  1  operation request.
  - cmd_ready  out  1  high only in IDLE.
  - cmd_intt  in  1  1 = INTT, 0 = FNTT.
  - cmd_sel_b  in  1  1 = polynomial B, 0 = polynomial A.
  - s_valid, s_ready  in/out  1  input coefficient handshake.
  - s_data  in  DW  input coefficient, natural order.
  - m_valid, m_ready  out/in  1  result coefficient handshake.
  - m_data  out  DW  result coefficient, natural order.
  - load_a_f, load_a_i, load_b_f, load_b_i  out  1  core load pulses.
  - read_a, read_b, start_ab, start_fntt, start_intt  out  1  core control pulses.
  - start_pwm2  out  1  tied 0.
  - din  out  DW  core data in.
  - dout  in  DW  core data out.
  - done  in  1  core completion.
  - busy  out  1  high in any state other than IDLE.
  - err  out  1  watchdog error flag.

Function
- REQ-003 SHALL contain one N x DW staging buffer, shared by input fill and result capture.
- REQ-004 States SHALL be IDLE, FILL, LOAD, GAP1, START, GAP2, WAIT, RGAP0, READ, RGAP, CAPT, DRAIN, ERR.
- REQ-005 IDLE: a cycle with cmd_valid=1 SHALL latch cmd_intt/cmd_sel_b and enter FILL.
- REQ-006 FILL: s_ready=1; each s_valid&s_ready beat SHALL write buffer[i], i=0..N-1; the beat with i=N-1 SHALL enter LOAD.
- REQ-007 LOAD cycle SHALL pulse exactly one load line for one cycle, selected by {sel_b, intt}: a_f, a_i, b_f or b_i.
- REQ-008 During the N cycles after the load pulse, din SHALL present buffer[4k+0], [4k+2], [4k+1], [4k+3] for k=0..N/4-1, one coefficient per cycle, with no gaps.
- REQ-009 After the last din, din SHALL return to 0 and the block SHALL idle 2 cycles (GAP1).
- REQ-010 START SHALL pulse start_intt or start_fntt for 1 cycle, with start_ab=sel_b in the same cycle.
- REQ-011 GAP2 SHALL last 2 cycles, and done SHALL be ignored during it.
- REQ-012 WAIT SHALL poll done; the first cycle with done=1 SHALL enter RGAP0.
- REQ-013 RGAP0 SHALL last 1 cycle, then READ SHALL pulse read_b (sel_b=1) or read_a (sel_b=0) for 1 cycle, followed by 2 idle cycles (RGAP).
- REQ-014 CAPT SHALL sample dout on N consecutive cycles, alternately writing buffer[m] and then buffer[m+N/2], for m=0..N/2-1.
- REQ-015 DRAIN SHALL emit buffer[0..N-1] in order on m_data.
- REQ-016 While m_valid=1 and m_ready=0, m_data SHALL hold stable.
- REQ-017 DRAIN SHALL return to IDLE on the beat that emits index N-1.
- REQ-018 Every control pulse SHALL be registered and exactly one cycle wide.
- REQ-019 cmd_valid outside IDLE and s_valid outside FILL SHALL be ignored.
- REQ-020 A done that is already high on WAIT entry SHALL be accepted immediately.
- REQ-021 Index counters SHALL wrap only through state exit, never mid-phase.

Reset
- REQ-022 Reset asserted at any time, including mid-load or mid-capture, SHALL force IDLE, all pulses 0, din=0, m_valid=0, s_ready=0, busy=0, err=0, counters=0; buffer contents SHALL be undefined.
- REQ-023 The first command SHALL be accepted no earlier than the first rising edge after reset deasserts.

Configuration
- REQ-024 With HOSTIF_DONE_TMO_EN defined: a cycle counter SHALL run in WAIT; reaching TMO without done SHALL enter ERR with err=1, holding until reset.
- REQ-025 Without HOSTIF_DONE_TMO_EN: there SHALL be no counter, WAIT SHALL wait indefinitely, err SHALL be tied 0, and ERR SHALL be unreachable.

Verification
- REQ-026 INTT on A with s_data=0..255 -> load_a_i pulse, then din 0,2,1,3,4,6,5,7..., then start_intt=1 with start_ab=0.
- REQ-027 Model core returns dout sequence 0,128,1,129,...,127,255 -> m_data emits 0..255 in order; checker expects 256 matches.
- REQ-028 FNTT on B -> load_b_f, start_fntt with start_ab=1, read_b; no other pulse lines toggle.
- REQ-029 m_ready toggled 1-of-3 cycles during DRAIN -> no lost or duplicated words, m_data stable while stalled.
- REQ-030 Reset low at din index 100 -> next cycle busy=0 and all pulses 0; a fresh command then completes correctly.
- REQ-031 With macro defined and TMO=64, done never asserted -> err=1 at WAIT cycle 64; without macro, busy stays 1 and err stays 0.
